// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word per valid/ready handshake, one bit per clock.
// Optional even-parity trailer bit is built in when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [WIDTH-1:0] iData,
  input  logic             iValid,
  output logic             oReady,
  output logic             oSerial,
  output logic             oFrame,
  output logic             oLast
);

`ifdef PISO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             serial_q, serial_d;
  logic             frame_q, frame_d;
  logic             last_q, last_d;
  logic             accept;
`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] CNT_DATA_LAST = CW'(WIDTH - 1);
  logic             par_q, par_d;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] d);
    if (MSB_FIRST) return d[WIDTH-1];
    return d[0];
  endfunction

  // The register holds only the bits still to be sent, so it is zero-filled as it drains.
  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] d);
    if (MSB_FIRST) return d << 1;
    return d >> 1;
  endfunction

  assign oReady  = (state_q == IDLE) || last_q;
  assign accept  = iValid && oReady;
  assign oSerial = serial_q;
  assign oFrame  = frame_q;
  assign oLast   = last_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    serial_d = serial_q;
    frame_d  = frame_q;
    last_d   = last_q;
`ifdef PISO_PARITY_EN
    par_d    = par_q;
`endif
    if (accept) begin
      // First bit goes straight to the output register; the rest wait in shreg.
      state_d  = SHIFT;
      shreg_d  = drop_bit(iData);
      cnt_d    = '0;
      serial_d = first_bit(iData);
      frame_d  = 1'b1;
      last_d   = 1'b0;
`ifdef PISO_PARITY_EN
      par_d    = ^iData;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          serial_d = 1'b0;
          frame_d  = 1'b0;
          last_d   = 1'b0;
        end
        SHIFT: begin
          if (last_q) begin
            state_d  = IDLE;
            shreg_d  = '0;
            cnt_d    = '0;
            serial_d = 1'b0;
            frame_d  = 1'b0;
            last_d   = 1'b0;
          end else begin
            cnt_d    = cnt_q + CW'(1);
            last_d   = (cnt_d == CNT_LAST);
            shreg_d  = drop_bit(shreg_q);
`ifdef PISO_PARITY_EN
            serial_d = (cnt_q == CNT_DATA_LAST) ? par_q : first_bit(shreg_q);
`else
            serial_d = first_bit(shreg_q);
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b0;
      frame_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      frame_q  <= frame_d;
      last_q   <= last_d;
`ifdef PISO_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: one MSB-first and one LSB-first instance share stimulus; a word-level model
// predicts accept times and bit streams, a negedge monitor compares every cycle.
module tb_piso_serializer;
  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             valid = 1'b0;
  logic             ready_m, serial_m, frame_m, last_m;
  logic             ready_l, serial_l, frame_l, last_l;

  int checks = 0;
  int failures = 0;

  // Expected bit streams per instance (0 = MSB first, 1 = LSB first) and frame cycles left to show.
  bit qs[2][$];
  int rem = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .iClk(clk), .iRst_n(rst_n), .iData(data), .iValid(valid),
    .oReady(ready_m), .oSerial(serial_m), .oFrame(frame_m), .oLast(last_m));

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .iClk(clk), .iRst_n(rst_n), .iData(data), .iValid(valid),
    .oReady(ready_l), .oSerial(serial_l), .oFrame(frame_l), .oLast(last_l));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a frame occupies N cycles; a new word can be taken when idle or on the final frame cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qs[0].delete();
      qs[1].delete();
      rem = 0;
    end else begin
      bit ready_exp;
      ready_exp = (rem <= 1);
      if (rem > 0) rem--;
      if (valid && ready_exp) begin
        for (int i = 0; i < WIDTH; i++) begin
          qs[0].push_back(data[WIDTH-1-i]);
          qs[1].push_back(data[i]);
        end
`ifdef PISO_PARITY_EN
        qs[0].push_back(^data);
        qs[1].push_back(^data);
`endif
        rem = N;
      end
    end
  end

  task automatic mon(input int idx, input string tag, input logic rdy, input logic ser,
                     input logic frm, input logic lst);
    check({tag, " ready"}, rdy, (rem <= 1));
    check({tag, " frame"}, frm, (rem > 0));
    if (rem > 0) begin
      check({tag, " queue_nonempty"}, qs[idx].size() != 0, 1);
      if (qs[idx].size() != 0) begin
        bit b;
        b = qs[idx].pop_front();
        check({tag, " serial"}, ser, b);
      end
      check({tag, " last"}, lst, (rem == 1));
    end else begin
      check({tag, " idle_serial"}, ser, 0);
      check({tag, " idle_last"}, lst, 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, "msb", ready_m, serial_m, frame_m, last_m);
    mon(1, "lsb", ready_l, serial_l, frame_l, last_l);
  end

  task automatic cyc(input logic v, input logic [WIDTH-1:0] d);
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", {ready_m, ready_l}, 2'b11);
    check("reset outs", {serial_m, frame_m, last_m, serial_l, frame_l, last_l}, 6'b0);
    rst_n = 1'b1;
    cyc(0, '0);

    // Single words: A5, then 01, with idle gaps.
    cyc(1, 8'hA5);
    repeat (N + 2) cyc(0, '0);
    cyc(1, 8'h01);
    repeat (N + 2) cyc(0, '0);

    // Back-to-back: 3C held valid until its acceptance on A5's final cycle.
    cyc(1, 8'hA5);
    repeat (N) cyc(1, 8'h3C);
    repeat (N + 2) cyc(0, '0);

    // Busy ignore: 0F offered during F0's frame.
    cyc(1, 8'hF0);
    repeat (N - 1) cyc(1, 8'h0F);
    cyc(1, 8'h0F);
    repeat (N + 2) cyc(0, '0);

    // Parity distinction word.
    cyc(1, 8'h07);
    repeat (N + 2) cyc(0, '0);

    // Asynchronous reset while bit 4 of FF is on the wire.
    cyc(1, 8'hFF);
    repeat (3) cyc(0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset outs", {serial_m, frame_m, last_m, serial_l, frame_l, last_l}, 6'b0);
    check("midreset ready", {ready_m, ready_l}, 2'b11);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (N + 2) cyc(0, '0);

    // Random traffic.
    for (int c = 0; c < 600; c++)
      cyc($urandom_range(0, 3) != 0, WIDTH'($urandom));
    repeat (N + 3) cyc(0, '0);

    check("drain msb", qs[0].size(), 0);
    check("drain lsb", qs[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
